irq_ctrl_multi: RTL and testbench

- Parametrised multi-source interrupt controller for the pipelined processor; replaces the single `interrupt` input wire.
- Detects rising edges on N_SRC request lines, latches them as pending, applies a software mask and fixed priority (index 0 highest).
- Presents one request plus a vector address to the fetch stage via a req/ack handshake; tracks in-service sources until the pipeline signals RTI.

---
 rtl/irq_ctrl_multi.sv | 146 ++++++++++++++
 tb/tb_irq_ctrl_multi.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_multi.sv
// Multi-source interrupt controller: rising-edge capture into a pending bitmap,
// software mask, fixed priority (index 0 highest), req/ack handshake towards
// fetch and in-service tracking retired by RTI.
// Optional feature macro: IRQ_NEST_EN (nested preemption by higher-priority
// sources while in service).
module irq_ctrl_multi #(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = '0,
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              cfg_we,
  input  logic [N_SRC-1:0]  cfg_wdata,
  input  logic              irq_ack,
  input  logic              rti,
  output logic              irq_req,
  output logic [ADDR_W-1:0] irq_vec,
  output logic [N_SRC-1:0]  pending,
  output logic [N_SRC-1:0]  in_service,
  output logic              rti_err
);

  localparam int unsigned IdxW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StServe} state_e;

  state_e            state_q, state_d;
  logic [N_SRC-1:0]  prev_q, pending_q, pending_d, mask_q, mask_d;
  logic [N_SRC-1:0]  in_service_q, in_service_d;
  logic [IdxW-1:0]   sel_q, sel_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic              req_q, req_d;
  logic              rti_err_q, rti_err_d;

  logic [N_SRC-1:0]  rise, cand, ack_mask, rti_mask;
  logic [IdxW-1:0]   cand_sel, hp;
  logic              cand_vld, ack_fire, rti_fire;

  // Lowest set index; returns 0 for an all-zero vector (callers gate on validity).
  function automatic logic [IdxW-1:0] lowest_idx(input logic [N_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IdxW'(i);
    end
  endfunction

  function automatic logic [ADDR_W-1:0] vec_of(input logic [IdxW-1:0] s);
    vec_of = VEC_BASE + ADDR_W'(s) * VEC_STRIDE;
  endfunction

  // Next-state logic for bitmaps, handshake and FSM.
  always_comb begin
    rise     = irq_in & ~prev_q;
    cand     = pending_q & mask_q;
    cand_vld = |cand;
    cand_sel = lowest_idx(cand);
    hp       = lowest_idx(in_service_q);

    ack_fire = (state_q == StReq) && irq_ack;
    ack_mask = ack_fire ? (N_SRC'(1) << sel_q) : '0;
    // RTI retires the lowest set in-service bit, using the pre-ack value.
    rti_fire = rti && (|in_service_q);
    rti_mask = rti_fire ? (in_service_q & (~in_service_q + N_SRC'(1))) : '0;

    // A new rising edge wins over an ack clear on the same bit.
    pending_d    = (pending_q & ~ack_mask) | rise;
    in_service_d = (in_service_q & ~rti_mask) | ack_mask;
    mask_d       = cfg_we ? cfg_wdata : mask_q;
    rti_err_d    = rti && !(|in_service_q);

    state_d = state_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    req_d   = req_q;

    unique case (state_q)
      StIdle: begin
        if (cand_vld) begin
          state_d = StReq;
          sel_d   = cand_sel;
          vec_d   = vec_of(cand_sel);
          req_d   = 1'b1;
        end
      end
      StReq: begin
        // Request stays latched until acked, even if masked or outranked.
        if (ack_fire) begin
          state_d = StServe;
          req_d   = 1'b0;
        end
      end
      StServe: begin
        if (in_service_d == '0) begin
          state_d = StIdle;
        end
`ifdef IRQ_NEST_EN
        else if (cand_vld && (cand_sel < hp)) begin
          state_d = StReq;
          sel_d   = cand_sel;
          vec_d   = vec_of(cand_sel);
          req_d   = 1'b1;
        end
`endif
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      prev_q       <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      in_service_q <= '0;
      sel_q        <= '0;
      vec_q        <= '0;
      req_q        <= 1'b0;
      rti_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= irq_in;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      sel_q        <= sel_d;
      vec_q        <= vec_d;
      req_q        <= req_d;
      rti_err_q    <= rti_err_d;
    end
  end

  assign irq_req    = req_q;
  assign irq_vec    = vec_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign rti_err    = rti_err_q;

endmodule

// File: tb/tb_irq_ctrl_multi.sv
// Directed bench for irq_ctrl_multi with default parameters (4 sources,
// vectors at 0,4,8,12). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, i.e. after the edge has settled.
module tb_irq_ctrl_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic        cfg_we;
  logic [3:0]  cfg_wdata;
  logic        irq_ack;
  logic        rti;
  logic        irq_req;
  logic [31:0] irq_vec;
  logic [3:0]  pending;
  logic [3:0]  in_service;
  logic        rti_err;

  int n_vec = 0;
  int n_err = 0;

  irq_ctrl_multi dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .cfg_we    (cfg_we),
    .cfg_wdata (cfg_wdata),
    .irq_ack   (irq_ack),
    .rti       (rti),
    .irq_req   (irq_req),
    .irq_vec   (irq_vec),
    .pending   (pending),
    .in_service(in_service),
    .rti_err   (rti_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [3:0] m);
    cfg_we = 1'b1; cfg_wdata = m; tick(); cfg_we = 1'b0;
  endtask

  task automatic pulse_in(input logic [3:0] v);
    irq_in = v; tick(); irq_in = 4'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic do_rti();
    rti = 1'b1; tick(); rti = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_in = '0; cfg_we = 0; cfg_wdata = '0; irq_ack = 0; rti = 0;
    tick(); tick(); reset = 1'b0;
    n_vec++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", irq_req); end
    n_vec++; if (irq_vec !== 32'd0) begin n_err++; $display("FAIL rst_vec got %0d want 0", irq_vec); end
    n_vec++; if (pending !== 4'b0) begin n_err++; $display("FAIL rst_pend got %b want 0000", pending); end
    n_vec++; if (in_service !== 4'b0) begin n_err++; $display("FAIL rst_insvc got %b want 0000", in_service); end
    n_vec++; if (rti_err !== 1'b0) begin n_err++; $display("FAIL rst_rtierr got %b want 0", rti_err); end
  endtask

  task automatic test_single();
    write_mask(4'b1111);
    pulse_in(4'b0100);
    n_vec++; if (pending !== 4'b0100) begin n_err++; $display("FAIL s_pend got %b want 0100", pending); end
    n_vec++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL s_req_early got %b want 0", irq_req); end
    tick();
    n_vec++; if (irq_req !== 1'b1) begin n_err++; $display("FAIL s_req got %b want 1", irq_req); end
    n_vec++; if (irq_vec !== 32'd8) begin n_err++; $display("FAIL s_vec got %0d want 8", irq_vec); end
    do_ack();
    n_vec++; if (in_service !== 4'b0100) begin n_err++; $display("FAIL s_insvc got %b want 0100", in_service); end
    n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL s_pend_ack got %b want 0000", pending); end
    n_vec++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL s_req_ack got %b want 0", irq_req); end
    do_rti();
    n_vec++; if (in_service !== 4'b0000) begin n_err++; $display("FAIL s_insvc_rti got %b want 0000", in_service); end
    n_vec++; if (rti_err !== 1'b0) begin n_err++; $display("FAIL s_rtierr got %b want 0", rti_err); end
  endtask

  task automatic test_priority();
    pulse_in(4'b1010);
    tick();
    n_vec++; if (irq_vec !== 32'd4 || irq_req !== 1'b1) begin n_err++; $display("FAIL p_first got req=%b vec=%0d want req=1 vec=4", irq_req, irq_vec); end
    do_ack();
    n_vec++; if (in_service !== 4'b0010 || pending !== 4'b1000) begin n_err++; $display("FAIL p_ack got insvc=%b pend=%b want 0010/1000", in_service, pending); end
    do_rti();
    n_vec++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL p_gap got %b want 0", irq_req); end
    tick();
    n_vec++; if (irq_vec !== 32'd12 || irq_req !== 1'b1) begin n_err++; $display("FAIL p_second got req=%b vec=%0d want req=1 vec=12", irq_req, irq_vec); end
    do_ack(); do_rti();
  endtask

  task automatic test_mask();
    write_mask(4'b1110);
    pulse_in(4'b0001);
    n_vec++; if (pending !== 4'b0001) begin n_err++; $display("FAIL m_pend got %b want 0001", pending); end
    tick(); tick();
    n_vec++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL m_masked got %b want 0", irq_req); end
    write_mask(4'b1111);
    n_vec++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL m_oldmask got %b want 0", irq_req); end
    tick();
    n_vec++; if (irq_req !== 1'b1 || irq_vec !== 32'd0) begin n_err++; $display("FAIL m_unmask got req=%b vec=%0d want req=1 vec=0", irq_req, irq_vec); end
    do_ack(); do_rti();
  endtask

  task automatic test_simultaneous();
    pulse_in(4'b0100);
    tick();
    n_vec++; if (irq_req !== 1'b1 || irq_vec !== 32'd8) begin n_err++; $display("FAIL x_req got req=%b vec=%0d want req=1 vec=8", irq_req, irq_vec); end
    irq_ack = 1'b1; irq_in = 4'b0100; tick(); irq_ack = 1'b0; irq_in = 4'b0;
    n_vec++; if (pending !== 4'b0100) begin n_err++; $display("FAIL x_setwins got %b want 0100", pending); end
    n_vec++; if (in_service !== 4'b0100) begin n_err++; $display("FAIL x_insvc got %b want 0100", in_service); end
    do_rti();
    tick();
    n_vec++; if (irq_req !== 1'b1 || irq_vec !== 32'd8) begin n_err++; $display("FAIL x_rereq got req=%b vec=%0d want req=1 vec=8", irq_req, irq_vec); end
    do_ack(); do_rti();
    n_vec++; if (pending !== 4'b0 || in_service !== 4'b0) begin n_err++; $display("FAIL x_clean got pend=%b insvc=%b want 0/0", pending, in_service); end
  endtask

  task automatic test_errors_reset();
    do_rti();
    n_vec++; if (rti_err !== 1'b1) begin n_err++; $display("FAIL e_rtierr got %b want 1", rti_err); end
    n_vec++; if (in_service !== 4'b0 || irq_req !== 1'b0) begin n_err++; $display("FAIL e_nochange got insvc=%b req=%b want 0/0", in_service, irq_req); end
    do_ack();
    n_vec++; if (rti_err !== 1'b0) begin n_err++; $display("FAIL e_pulse got %b want 0", rti_err); end
    n_vec++; if (in_service !== 4'b0) begin n_err++; $display("FAIL e_stray_ack got %b want 0000", in_service); end
    pulse_in(4'b0010);
    tick();
    n_vec++; if (irq_req !== 1'b1 || irq_vec !== 32'd4) begin n_err++; $display("FAIL e_req got req=%b vec=%0d want req=1 vec=4", irq_req, irq_vec); end
    reset = 1'b1; irq_ack = 1'b1; irq_in = 4'b1000; tick();
    reset = 1'b0; irq_ack = 1'b0; irq_in = 4'b0;
    n_vec++; if (irq_req !== 1'b0 || irq_vec !== 32'd0) begin n_err++; $display("FAIL e_rst_req got req=%b vec=%0d want 0/0", irq_req, irq_vec); end
    n_vec++; if (pending !== 4'b0 || in_service !== 4'b0) begin n_err++; $display("FAIL e_rst_maps got pend=%b insvc=%b want 0/0", pending, in_service); end
    // Mask was cleared by reset, so a new edge stays pending only.
    pulse_in(4'b0010);
    tick(); tick();
    n_vec++; if (pending !== 4'b0010 || irq_req !== 1'b0) begin n_err++; $display("FAIL e_rst_mask got pend=%b req=%b want 0010/0", pending, irq_req); end
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_nest();
    write_mask(4'b1111);
    pulse_in(4'b0100);
    tick(); do_ack();
    n_vec++; if (in_service !== 4'b0100) begin n_err++; $display("FAIL n_insvc got %b want 0100", in_service); end
    pulse_in(4'b0001);
    tick();
`ifdef IRQ_NEST_EN
    n_vec++; if (irq_req !== 1'b1 || irq_vec !== 32'd0) begin n_err++; $display("FAIL n_preempt got req=%b vec=%0d want req=1 vec=0", irq_req, irq_vec); end
    do_ack();
    n_vec++; if (in_service !== 4'b0101) begin n_err++; $display("FAIL n_both got %b want 0101", in_service); end
    do_rti();
    n_vec++; if (in_service !== 4'b0100) begin n_err++; $display("FAIL n_rti1 got %b want 0100", in_service); end
    do_rti();
    n_vec++; if (in_service !== 4'b0000 || irq_req !== 1'b0) begin n_err++; $display("FAIL n_rti2 got insvc=%b req=%b want 0000/0", in_service, irq_req); end
`else
    n_vec++; if (irq_req !== 1'b0 || pending !== 4'b0001) begin n_err++; $display("FAIL n_held got req=%b pend=%b want 0/0001", irq_req, pending); end
    do_rti();
    n_vec++; if (in_service !== 4'b0000 || irq_req !== 1'b0) begin n_err++; $display("FAIL n_rti got insvc=%b req=%b want 0000/0", in_service, irq_req); end
    tick();
    n_vec++; if (irq_req !== 1'b1 || irq_vec !== 32'd0) begin n_err++; $display("FAIL n_after got req=%b vec=%0d want req=1 vec=0", irq_req, irq_vec); end
    do_ack();
    n_vec++; if (in_service !== 4'b0001) begin n_err++; $display("FAIL n_single got %b want 0001", in_service); end
    do_rti();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_simultaneous();
    test_errors_reset();
    test_nest();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
